swc_ob_prio_dequeue: RTL and testbench
======================================

# swc_ob_prio_dequeue

Read-side controller for the switch-core output buffer. It sits behind the bank of `swc_ob_prio_queue` instances, one per priority. It selects the highest-priority non-empty queue and reads the entry at that queue's read pointer from the shared output-buffer RAM. It pulses that queue's `read_i`, then presents the fetched page address downstream on a valid/ack handshake.

## Interface
Parameters:
- `g_num_prio`, 8, number of priority queues; index `g_num_prio-1` is the highest priority
- `g_prio_bits`, 3, width of the priority index (clog2 of `g_num_prio`)
- `g_queue_addr_bits`, 4, per-queue address width (16 entries per queue)
- `g_data_width`, 10, width of a stored entry (page address)

Ports:
- `clk_i`  in  1  system clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `not_empty_i`  in  `g_num_prio`  per-queue not_empty flag
- `rd_addr_i`  in  `g_num_prio*g_queue_addr_bits`  flattened per-queue read pointers; queue k occupies bits `[k*4+3:k*4]`
- `read_o`  out  `g_num_prio`  one-hot read strobe, bit k drives queue k `read_i`
- `ram_rd_addr_o`  out  `g_prio_bits+g_queue_addr_bits`  shared RAM address `{prio, rd_addr}`
- `ram_rd_data_i`  in  `g_data_width`  synchronous RAM read data, 1-cycle latency
- `dout_o`  out  `g_data_width`  dequeued entry
- `dout_prio_o`  out  `g_prio_bits`  priority of the dequeued entry
- `dout_valid_o`  out  1  `dout_o` and `dout_prio_o` are valid
- `dout_ack_i`  in  1  downstream accepts the entry

## Operation
The FSM has four states: IDLE, READ, LATCH, VALID.

- **IDLE**
  - If `not_empty_i != 0`, compute `sel` = index of the highest set bit.
  - Register `sel` and `ram_rd_addr_o <= {sel, rd_addr_i[sel]}`, then go to READ.
  - Otherwise stay in IDLE.
- **READ**
  - `read_o[sel] = 1` for exactly this one cycle; all other bits are 0.
  - `ram_rd_addr_o` is held stable. The RAM samples it at the end of this cycle.
  - Go to LATCH.
- **LATCH**
  - `dout_o <= ram_rd_data_i` and `dout_prio_o <= sel`.
  - Go to VALID.
- **VALID**
  - `dout_valid_o = 1`.
  - Hold `dout_o` and `dout_prio_o` until `dout_ack_i = 1`.
  - On ack, go to IDLE. Selection resumes from the next cycle.

Rules:
- Arbitration is strict priority with no fairness. A continuously non-empty high queue starves lower queues by design.
- `not_empty_i` is sampled only in IDLE. Changes during READ, LATCH or VALID are ignored until the next IDLE. This guarantees that the strobed queue's pointer and flag have settled before reselection.
- Pointer wrap-around belongs to the queue. This block uses `rd_addr_i[sel]` verbatim (e.g. 15, then 0 on the next read).
- `read_o` is one-hot or zero at all times and is never asserted outside READ.
- `dout_ack_i` outside VALID is ignored.

## Timing
Reset values (asynchronous, all outputs): state = IDLE, `read_o = 0`, `ram_rd_addr_o = 0`, `dout_o = 0`, `dout_prio_o = 0`, `dout_valid_o = 0`.

- **Latency.** Let T be the IDLE cycle with `not_empty_i != 0`.
  - `read_o` pulses at T+1.
  - Data is captured at the end of T+2.
  - `dout_valid_o` is high from T+3.
- **Throughput.** With ack held high, one entry every 4 cycles: IDLE, READ, LATCH, VALID.
- **Backpressure.** With ack low, VALID is held indefinitely. No further `read_o` is issued and outputs stay stable.
- **Reset mid-operation.** The FSM returns to IDLE immediately and `dout_valid_o` drops. An entry whose `read_o` has already pulsed is discarded; queues are reset together with this block at system level.
- **Simultaneous events.** Ack in VALID together with new `not_empty_i` bits: the transition to IDLE happens first and selection occurs on the following cycle.

## Test plan
- **Single entry.** Only `not_empty_i[3]=1`, `rd_addr_i[3]=5`, RAM at addr 0x35 = 0x2A7, ack tied high.
  - `read_o = 0x08` for exactly one cycle.
  - `ram_rd_addr_o = 0x35`.
  - `dout_o = 0x2A7`, `dout_prio_o = 3`, `dout_valid_o` high for 1 cycle, 3 cycles after selection.
- **Priority.** `not_empty_i = 0x24` (queues 2 and 5).
  - First dequeue is prio 5 with `read_o = 0x20`.
  - After queue 5 empties, prio 2 with `read_o = 0x04`.
- **Backpressure.** Ack low for 10 cycles in VALID.
  - `dout_valid_o` stays high and `dout_o` is stable.
  - `read_o` stays 0 throughout.
  - A single read follows the ack.
- **Wrap.** Queue 7 `rd_addr` goes 14, 15, 0 across three dequeues.
  - `ram_rd_addr_o` = 0x7E, 0x7F, 0x70.
- **Burst and throughput.** Queue 0 holds 16 entries (full), ack high.
  - 16 dequeues in 64 cycles with in-order data.
  - No `read_o` after `not_empty_i[0]` falls.
- **Reset mid-op.** Assert `rst_n_i` low during LATCH.
  - All outputs are 0 asynchronously.
  - After release, with `not_empty_i = 0`, the block remains idle with no `read_o`.

Source files
------------

// File: rtl/swc_ob_prio_dequeue.sv
// Output-buffer read-side controller: strict-priority queue select,
// shared RAM fetch and valid/ack presentation of the dequeued entry.
module swc_ob_prio_dequeue #(
    parameter int g_num_prio        = 8,
    parameter int g_prio_bits       = 3,
    parameter int g_queue_addr_bits = 4,
    parameter int g_data_width      = 10
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic [g_num_prio-1:0]                     not_empty_i,
    input  logic [g_num_prio*g_queue_addr_bits-1:0]   rd_addr_i,
    output logic [g_num_prio-1:0]                     read_o,
    output logic [g_prio_bits+g_queue_addr_bits-1:0]  ram_rd_addr_o,
    input  logic [g_data_width-1:0]                   ram_rd_data_i,
    output logic [g_data_width-1:0]                   dout_o,
    output logic [g_prio_bits-1:0]                    dout_prio_o,
    output logic                                      dout_valid_o,
    input  logic                                      dout_ack_i
);

    localparam int AW = g_prio_bits + g_queue_addr_bits;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_VALID
    } state_t;

    state_t                         state_q, state_d;
    logic [g_prio_bits-1:0]         sel_q, sel_d;
    logic [AW-1:0]                  addr_q, addr_d;
    logic [g_data_width-1:0]        dout_q, dout_d;
    logic [g_prio_bits-1:0]         prio_q, prio_d;
    logic [g_prio_bits-1:0]         pick;
    logic [g_queue_addr_bits-1:0]   pick_addr;

    // Highest set not_empty bit wins; its read pointer travels with it.
    always_comb begin
        pick      = '0;
        pick_addr = '0;
        for (int k = 0; k < g_num_prio; k++) begin
            if (not_empty_i[k]) begin
                pick      = g_prio_bits'(k);
                pick_addr = rd_addr_i[k*g_queue_addr_bits +: g_queue_addr_bits];
            end
        end
    end

    // Next-state and output decode; flags are only sampled in IDLE.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        dout_d       = dout_q;
        prio_d       = prio_q;
        read_o       = '0;
        dout_valid_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|not_empty_i) begin
                    sel_d   = pick;
                    addr_d  = {pick, pick_addr};
                    state_d = S_READ;
                end
            end
            S_READ: begin
                read_o[sel_q] = 1'b1;
                state_d       = S_LATCH;
            end
            S_LATCH: begin
                dout_d  = ram_rd_data_i;
                prio_d  = sel_q;
                state_d = S_VALID;
            end
            S_VALID: begin
                dout_valid_o = 1'b1;
                if (dout_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            prio_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            prio_q  <= prio_d;
        end
    end

    assign ram_rd_addr_o = addr_q;
    assign dout_o        = dout_q;
    assign dout_prio_o   = prio_q;

endmodule

// File: tb/tb_swc_ob_prio_dequeue.sv
// Directed bench for swc_ob_prio_dequeue with a small queue-bank
// model and a 1-cycle synchronous RAM model.
module tb_swc_ob_prio_dequeue;

    logic        clk;
    logic        rst_n;
    logic [7:0]  not_empty;
    logic [31:0] rd_addr;
    logic [7:0]  read_o;
    logic [6:0]  ram_addr;
    logic [9:0]  ram_data;
    logic [9:0]  dout;
    logic [2:0]  dout_prio;
    logic        dout_valid;
    logic        ack;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int bad_onehot = 0;

    logic [9:0] ram [128];
    logic [4:0] cnt [8];
    logic [3:0] rptr [8];
    logic       ld;
    logic [4:0] ld_cnt [8];
    logic [3:0] ld_ptr [8];

    swc_ob_prio_dequeue dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .not_empty_i   (not_empty),
        .rd_addr_i     (rd_addr),
        .read_o        (read_o),
        .ram_rd_addr_o (ram_addr),
        .ram_rd_data_i (ram_data),
        .dout_o        (dout),
        .dout_prio_o   (dout_prio),
        .dout_valid_o  (dout_valid),
        .dout_ack_i    (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // synchronous RAM, one cycle read latency
    always @(posedge clk) ram_data <= ram[ram_addr];

    // queue bank model: pointer advances and count drops on read strobe
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                cnt[k]  <= '0;
                rptr[k] <= '0;
            end
        end else if (ld) begin
            for (int k = 0; k < 8; k++) begin
                cnt[k]  <= ld_cnt[k];
                rptr[k] <= ld_ptr[k];
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (read_o[k]) begin
                    cnt[k]  <= cnt[k] - 5'd1;
                    rptr[k] <= rptr[k] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        not_empty = '0;
        rd_addr   = '0;
        for (int k = 0; k < 8; k++) begin
            not_empty[k]      = (cnt[k] != 0);
            rd_addr[k*4 +: 4] = rptr[k];
        end
    end

    always @(posedge clk) if (read_o != 0) pulses <= pulses + 1;
    always @(negedge clk) if ($countones(read_o) > 1) bad_onehot <= bad_onehot + 1;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic clr_ld();
        for (int k = 0; k < 8; k++) begin
            ld_cnt[k] = '0;
            ld_ptr[k] = '0;
        end
    endtask

    task automatic set_q(input int q, input int c, input int p);
        ld_cnt[q] = 5'(c);
        ld_ptr[q] = 4'(p);
    endtask

    task automatic commit();
        ld = 1'b1;
        step();
        ld = 1'b0;
        clr_ld();
    endtask

    task automatic wait_read(output bit ok);
        int n = 0;
        do begin
            step();
            n++;
        end while (read_o == 0 && n < 20);
        ok = (read_o != 0);
    endtask

    task automatic wait_valid(output bit ok, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!dout_valid && n < 40);
        ok = dout_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ack   = 1'b1;
        ld    = 1'b0;
        clr_ld();
        step();
        step();
        checks++;
        if ({read_o, ram_addr, dout, dout_prio, dout_valid} !== '0) begin
            errors++;
            $display("FAIL reset: rd=%h addr=%h dout=%h prio=%0d v=%b exp all 0",
                     read_o, ram_addr, dout, dout_prio, dout_valid);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        int p0;
        ram[7'h35] = 10'h2A7;
        p0 = pulses;
        set_q(3, 1, 5);
        commit();
        checks++;
        if (read_o !== 8'h00) begin
            errors++; $display("FAIL single_idle: read_o=%h exp 00", read_o);
        end
        step();
        checks++;
        if (read_o !== 8'h08 || ram_addr !== 7'h35) begin
            errors++;
            $display("FAIL single_read: read_o=%h addr=%h exp 08 35", read_o, ram_addr);
        end
        step();
        checks++;
        if (read_o !== 8'h00 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latch: read_o=%h v=%b exp 00 0", read_o, dout_valid);
        end
        step();
        checks++;
        if (dout_valid !== 1'b1 || dout !== 10'h2A7 || dout_prio !== 3'd3) begin
            errors++;
            $display("FAIL single_valid: v=%b dout=%h prio=%0d exp 1 2a7 3",
                     dout_valid, dout, dout_prio);
        end
        step();
        checks++;
        if (dout_valid !== 1'b0 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL single_done: v=%b pulses=%0d exp 0 1", dout_valid, pulses - p0);
        end
    endtask

    task automatic test_priority();
        bit ok;
        int n;
        ram[7'h50] = 10'h155;
        ram[7'h20] = 10'h0AA;
        set_q(2, 1, 0);
        set_q(5, 1, 0);
        commit();
        wait_read(ok);
        checks++;
        if (!ok || read_o !== 8'h20 || ram_addr !== 7'h50) begin
            errors++;
            $display("FAIL prio_first: read_o=%h addr=%h exp 20 50", read_o, ram_addr);
        end
        wait_valid(ok, n);
        checks++;
        if (!ok || dout !== 10'h155 || dout_prio !== 3'd5) begin
            errors++;
            $display("FAIL prio_first_data: dout=%h prio=%0d exp 155 5", dout, dout_prio);
        end
        wait_read(ok);
        checks++;
        if (!ok || read_o !== 8'h04 || ram_addr !== 7'h20) begin
            errors++;
            $display("FAIL prio_second: read_o=%h addr=%h exp 04 20", read_o, ram_addr);
        end
        wait_valid(ok, n);
        checks++;
        if (!ok || dout !== 10'h0AA || dout_prio !== 3'd2) begin
            errors++;
            $display("FAIL prio_second_data: dout=%h prio=%0d exp 0aa 2", dout, dout_prio);
        end
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        int n;
        int p0;
        int bad = 0;
        ram[7'h13] = 10'h111;
        ram[7'h14] = 10'h222;
        ack = 1'b0;
        p0 = pulses;
        set_q(1, 2, 3);
        commit();
        wait_valid(ok, n);
        checks++;
        if (!ok || dout !== 10'h111 || dout_prio !== 3'd1) begin
            errors++;
            $display("FAIL bp_first: dout=%h prio=%0d exp 111 1", dout, dout_prio);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (dout_valid !== 1'b1 || dout !== 10'h111 || read_o !== 8'h00) bad++;
        end
        checks++;
        if (bad != 0 || pulses - p0 != 1) begin
            errors++;
            $display("FAIL bp_hold: bad=%0d pulses=%0d exp 0 1", bad, pulses - p0);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        wait_read(ok);
        checks++;
        if (!ok || read_o !== 8'h02 || ram_addr !== 7'h14) begin
            errors++;
            $display("FAIL bp_next_read: read_o=%h addr=%h exp 02 14", read_o, ram_addr);
        end
        wait_valid(ok, n);
        checks++;
        if (!ok || dout !== 10'h222) begin
            errors++; $display("FAIL bp_next_data: dout=%h exp 222", dout);
        end
        ack = 1'b1;
        step();
    endtask

    task automatic test_wrap();
        bit ok;
        int n;
        logic [6:0] ea [3];
        logic [9:0] ed [3];
        ea[0] = 7'h7E; ea[1] = 7'h7F; ea[2] = 7'h70;
        ed[0] = 10'h3E1; ed[1] = 10'h3E2; ed[2] = 10'h3E3;
        for (int i = 0; i < 3; i++) ram[ea[i]] = ed[i];
        set_q(7, 3, 14);
        commit();
        for (int i = 0; i < 3; i++) begin
            wait_read(ok);
            checks++;
            if (!ok || ram_addr !== ea[i] || read_o !== 8'h80) begin
                errors++;
                $display("FAIL wrap_addr%0d: addr=%h read_o=%h exp %h 80",
                         i, ram_addr, read_o, ea[i]);
            end
            wait_valid(ok, n);
            checks++;
            if (!ok || dout !== ed[i] || dout_prio !== 3'd7) begin
                errors++;
                $display("FAIL wrap_data%0d: dout=%h prio=%0d exp %h 7",
                         i, dout, dout_prio, ed[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        int total = 0;
        int p0;
        int late = 0;
        for (int i = 0; i < 16; i++) ram[i] = 10'(10'h200 + i);
        p0 = pulses;
        set_q(0, 16, 0);
        commit();
        for (int i = 0; i < 16; i++) begin
            wait_valid(ok, n);
            total += n;
            checks++;
            if (!ok || dout !== 10'(10'h200 + i) || dout_prio !== 3'd0) begin
                errors++;
                $display("FAIL burst_data%0d: dout=%h prio=%0d exp %h 0",
                         i, dout, dout_prio, 10'(10'h200 + i));
            end
        end
        checks++;
        if (total != 63) begin
            errors++; $display("FAIL burst_cycles: steps=%0d exp 63", total);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            if (read_o !== 8'h00) late++;
        end
        checks++;
        if (late != 0 || pulses - p0 != 16) begin
            errors++;
            $display("FAIL burst_tail: late=%0d pulses=%0d exp 0 16", late, pulses - p0);
        end
    endtask

    task automatic test_reset_midop();
        int bad = 0;
        ram[7'h62] = 10'h0C3;
        set_q(6, 1, 2);
        commit();
        step();
        step();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({read_o, ram_addr, dout, dout_prio, dout_valid} !== '0) begin
            errors++;
            $display("FAIL rst_midop: rd=%h addr=%h dout=%h prio=%0d v=%b exp all 0",
                     read_o, ram_addr, dout, dout_prio, dout_valid);
        end
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (read_o !== 8'h00 || dout_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL rst_idle: bad=%0d exp 0", bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = '0;
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_wrap();
        test_back_to_back();
        test_reset_midop();
        checks++;
        if (bad_onehot != 0) begin
            errors++; $display("FAIL onehot: violations=%0d exp 0", bad_onehot);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
